// File: rtl/rgb_pwm_fader_if.sv
// rgb_pwm_fader bus: colour targets in, LED pins and status out.
// Parameterised so level widths follow PWM_BITS.
interface rgb_pwm_fader_if #(
  parameter int PWM_BITS = 8
);
  logic [PWM_BITS-1:0] r_i;
  logic [PWM_BITS-1:0] g_i;
  logic [PWM_BITS-1:0] b_i;
  logic                load_i;
  logic                led_r_o;
  logic                led_g_o;
  logic                led_b_o;
  logic                busy_o;
  logic                period_o;

  modport master (
    output r_i,
    output g_i,
    output b_i,
    output load_i,
    input  led_r_o,
    input  led_g_o,
    input  led_b_o,
    input  busy_o,
    input  period_o
  );

  modport slave (
    input  r_i,
    input  g_i,
    input  b_i,
    input  load_i,
    output led_r_o,
    output led_g_o,
    output led_b_o,
    output busy_o,
    output period_o
  );
endinterface

// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM LED driver with linear fading toward loaded targets.
// Levels only move at period boundaries, so pulses are never truncated.
module rgb_pwm_fader #(
  parameter int PWM_BITS     = 8,
  parameter int FADE_PERIODS = 4,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rgb_pwm_fader_if.slave bus
);

  localparam int FW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam int FL = (FADE_PERIODS > 0) ? FADE_PERIODS - 1 : 0;

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);
  localparam logic [FW-1:0]       FD_ONE  = FW'(1);
  localparam logic [FW-1:0]       FD_LAST = FW'(FL);
  localparam logic                LED_OFF = ACTIVE_LOW;

  typedef logic [2:0][PWM_BITS-1:0] lvl3_t;

  logic [PWM_BITS-1:0] r_cnt;
  logic [FW-1:0]       r_fade;
  lvl3_t               r_cur;
  lvl3_t               r_tgt;
  logic [2:0]          r_led;
  logic                r_busy;
  logic                r_period;

  lvl3_t               w_in;
  lvl3_t               w_cur_nxt;
  lvl3_t               w_tgt_nxt;
  logic [FW-1:0]       w_fade_nxt;
  logic                w_end;
  logic                w_step;
  logic                w_busy_nxt;

  assign w_in  = {bus.b_i, bus.g_i, bus.r_i};
  assign w_end = (r_cnt == CNT_MAX);

  always_comb begin
    w_fade_nxt = r_fade;
    w_step     = 1'b0;
    if (w_end) begin
      if (FADE_PERIODS == 0) begin
        w_step = 1'b1;
      end else if (r_fade == FD_LAST) begin
        w_fade_nxt = '0;
        w_step     = 1'b1;
      end else begin
        w_fade_nxt = r_fade + FD_ONE;
      end
    end
  end

  // Step compares against the targets held before this edge
  always_comb begin
    w_cur_nxt = r_cur;
    for (int ch = 0; ch < 3; ch++) begin
      if (w_step) begin
        if (FADE_PERIODS == 0) begin
          w_cur_nxt[ch] = r_tgt[ch];
        end else if (r_cur[ch] < r_tgt[ch]) begin
          w_cur_nxt[ch] = r_cur[ch] + LVL_ONE;
        end else if (r_cur[ch] > r_tgt[ch]) begin
          w_cur_nxt[ch] = r_cur[ch] - LVL_ONE;
        end
      end
    end
  end

  always_comb begin
    w_tgt_nxt  = bus.load_i ? w_in : r_tgt;
    w_busy_nxt = (w_cur_nxt != w_tgt_nxt);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_fade   <= '0;
      r_cur    <= '0;
      r_tgt    <= '0;
      r_led    <= {3{LED_OFF}};
      r_busy   <= 1'b0;
      r_period <= 1'b0;
    end else begin
      r_cnt    <= r_cnt + LVL_ONE;
      r_fade   <= w_fade_nxt;
      r_cur    <= w_cur_nxt;
      r_tgt    <= w_tgt_nxt;
      r_busy   <= w_busy_nxt;
      r_period <= (r_cnt == '0);
      for (int ch = 0; ch < 3; ch++) begin
        r_led[ch] <= (r_cur[ch] > r_cnt) ^ LED_OFF;
      end
    end
  end

  assign bus.led_r_o  = r_led[0];
  assign bus.led_g_o  = r_led[1];
  assign bus.led_b_o  = r_led[2];
  assign bus.busy_o   = r_busy;
  assign bus.period_o = r_period;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: three 4-bit instances (jump, jump active-low,
// two-period fade) share clock, reset and stimulus.
module tb_rgb_pwm_fader;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rgb_pwm_fader_if #(.PWM_BITS(4)) b0 ();
  rgb_pwm_fader_if #(.PWM_BITS(4)) b1 ();
  rgb_pwm_fader_if #(.PWM_BITS(4)) b2 ();

  rgb_pwm_fader #(
    .PWM_BITS(4), .FADE_PERIODS(0), .ACTIVE_LOW(1'b0)
  ) u0 (.clk_i(clk), .rst_i(rst), .bus(b0.slave));

  rgb_pwm_fader #(
    .PWM_BITS(4), .FADE_PERIODS(0), .ACTIVE_LOW(1'b1)
  ) u1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));

  rgb_pwm_fader #(
    .PWM_BITS(4), .FADE_PERIODS(2), .ACTIVE_LOW(1'b0)
  ) u2 (.clk_i(clk), .rst_i(rst), .bus(b2.slave));

  typedef struct {
    logic [3:0] r, g, b;
    int per;
    int dut;
    int er, eg, eb;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  int n_chk  = 0;
  int n_fail = 0;
  int duty [3][3];

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(logic [3:0] r, logic [3:0] g,
                        logic [3:0] b, logic ld);
    b0.r_i = r; b0.g_i = g; b0.b_i = b; b0.load_i = ld;
    b1.r_i = r; b1.g_i = g; b1.b_i = b; b1.load_i = ld;
    b2.r_i = r; b2.g_i = g; b2.b_i = b; b2.load_i = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] leds(int d);
    case (d)
      0:       return {b0.led_b_o, b0.led_g_o, b0.led_r_o};
      1:       return {b1.led_b_o, b1.led_g_o, b1.led_r_o};
      default: return {b2.led_b_o, b2.led_g_o, b2.led_r_o};
    endcase
  endfunction

  function automatic logic [2:0] busys();
    return {b2.busy_o, b1.busy_o, b0.busy_o};
  endfunction

  function automatic logic [2:0] pers();
    return {b2.period_o, b1.period_o, b0.period_o};
  endfunction

  // Leaves the bench on sample s=0: first period start after release
  task automatic reset_load(logic [3:0] r, logic [3:0] g,
                            logic [3:0] b, logic ld);
    rst = 1'b1;
    set_in(r, g, b, ld);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    set_in(r, g, b, 1'b0);
  endtask

  task automatic measure();
    logic [2:0] l;
    int pc;
    pc = 0;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 3; c++) duty[d][c] = 0;
    for (int k = 0; k < 16; k++) begin
      for (int d = 0; d < 3; d++) begin
        l = leds(d);
        for (int c = 0; c < 3; c++) duty[d][c] += int'(l[c]);
      end
      pc += int'(b0.period_o);
      tick();
    end
    check("period_o spacing",
          (pc == 1 && b0.period_o) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int done;
    bit have;
    logic [3:0] lr, lg, lb;
    int acc;
    int exp_ret [14];
    int exp_dn  [26];

    vt[0]  = '{4'd5, 4'd0, 4'd15, 0, 0, 0, 0, 0};
    vt[1]  = '{4'd5, 4'd0, 4'd15, 0, 1, 16, 16, 16};
    vt[2]  = '{4'd5, 4'd0, 4'd15, 1, 0, 5, 0, 15};
    vt[3]  = '{4'd5, 4'd0, 4'd15, 1, 1, 11, 16, 1};
    vt[4]  = '{4'd5, 4'd0, 4'd15, 6, 2, 3, 0, 3};
    vt[5]  = '{4'd3, 4'd0, 4'd0, 0, 2, 0, 0, 0};
    vt[6]  = '{4'd3, 4'd0, 4'd0, 1, 2, 0, 0, 0};
    vt[7]  = '{4'd3, 4'd0, 4'd0, 2, 2, 1, 0, 0};
    vt[8]  = '{4'd3, 4'd0, 4'd0, 3, 2, 1, 0, 0};
    vt[9]  = '{4'd3, 4'd0, 4'd0, 4, 2, 2, 0, 0};
    vt[10] = '{4'd3, 4'd0, 4'd0, 5, 2, 2, 0, 0};
    vt[11] = '{4'd3, 4'd0, 4'd0, 6, 2, 3, 0, 0};
    vt[12] = '{4'd3, 4'd0, 4'd0, 7, 2, 3, 0, 0};

    exp_ret = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2};
    exp_dn  = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6,
                6, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0};

    rst = 1'b1;
    set_in(4'd0, 4'd0, 4'd0, 1'b0);
    #1;
    check("reset leds u0", int'(leds(0)), 0);
    check("reset leds u1", int'(leds(1)), 7);
    check("reset busy", int'(busys()), 0);
    check("reset period", int'(pers()), 0);

    // Table-driven duty checks
    done = 0;
    have = 1'b0;
    lr = '0; lg = '0; lb = '0;
    for (int i = 0; i < NV; i++) begin
      if (!have || vt[i].r != lr || vt[i].g != lg ||
          vt[i].b != lb || vt[i].per < done - 1) begin
        reset_load(vt[i].r, vt[i].g, vt[i].b, 1'b1);
        done = 0;
        have = 1'b1;
        lr = vt[i].r; lg = vt[i].g; lb = vt[i].b;
      end
      while (done <= vt[i].per) begin
        measure();
        done++;
      end
      check($sformatf("vec%0d dut%0d r", i, vt[i].dut),
            duty[vt[i].dut][0], vt[i].er);
      check($sformatf("vec%0d dut%0d g", i, vt[i].dut),
            duty[vt[i].dut][1], vt[i].eg);
      check($sformatf("vec%0d dut%0d b", i, vt[i].dut),
            duty[vt[i].dut][2], vt[i].eb);
    end

    // busy_o falls right after the final step edge
    reset_load(4'd3, 4'd0, 4'd0, 1'b1);
    for (int s = 0; s < 97; s++) begin
      if (s == 0)  check("busy u2 s0", int'(b2.busy_o), 1);
      if (s == 14) check("busy u0 s14", int'(b0.busy_o), 1);
      if (s == 15) check("busy u0 s15", int'(b0.busy_o), 0);
      if (s == 94) check("busy u2 s94", int'(b2.busy_o), 1);
      if (s == 95) check("busy u2 s95", int'(b2.busy_o), 0);
      tick();
    end

    // Retarget mid-fade 0->10, reload 2 once level is 4
    reset_load(4'd10, 4'd0, 4'd0, 1'b1);
    acc = 0;
    for (int s = 0; s < 14 * 16; s++) begin
      acc += int'(b2.led_r_o);
      check($sformatf("retarget busy s%0d", s),
            int'(b2.busy_o), (s < 191) ? 1 : 0);
      if (s % 16 == 15) begin
        check($sformatf("retarget duty p%0d", s / 16),
              acc, exp_ret[s / 16]);
        acc = 0;
      end
      if (s == 132) set_in(4'd2, 4'd0, 4'd0, 1'b1);
      if (s == 133) set_in(4'd2, 4'd0, 4'd0, 1'b0);
      tick();
    end

    // Load lands on the step edge: step still heads for old target
    reset_load(4'd8, 4'd0, 4'd0, 1'b1);
    acc = 0;
    for (int s = 0; s < 26 * 16; s++) begin
      acc += int'(b2.led_r_o);
      if (s == 200 || s == 382 || s == 383)
        check($sformatf("down busy s%0d", s),
              int'(b2.busy_o), (s < 383) ? 1 : 0);
      if (s % 16 == 15) begin
        check($sformatf("down duty p%0d", s / 16),
              acc, exp_dn[s / 16]);
        acc = 0;
      end
      if (s == 190) set_in(4'd0, 4'd0, 4'd0, 1'b1);
      if (s == 191) set_in(4'd0, 4'd0, 4'd0, 1'b0);
      tick();
    end

    // Asynchronous reset mid-period with all levels at 9
    reset_load(4'd9, 4'd9, 4'd9, 1'b1);
    for (int s = 0; s < 32; s++) tick();
    check("pre-rst led u0", int'(leds(0)), 7);
    check("pre-rst led u1", int'(leds(1)), 0);
    check("pre-rst period", int'(b0.period_o), 1);
    check("pre-rst busy u2", int'(b2.busy_o), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst led u0", int'(leds(0)), 0);
    check("async rst led u1", int'(leds(1)), 7);
    check("async rst led u2", int'(leds(2)), 0);
    check("async rst busy", int'(busys()), 0);
    check("async rst period", int'(pers()), 0);
    @(negedge clk);
    rst = 1'b0;
    acc = 0;
    for (int s = 0; s < 32; s++) begin
      tick();
      acc += int'(leds(0) != 3'b000) + int'(leds(2) != 3'b000);
      acc += int'(leds(1) != 3'b111);
    end
    check("post-rst leds stay off", acc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
